// File: rtl/alu_reg_pipeline.sv
// Two-stage integer ALU pipeline: operand collect (OC) then writeback (WB).
// Operands arrive from the forward bus (first OC cycle) or PRF read acks.
package core_types_pkg;
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 6;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
endpackage

module alu_reg_pipeline
  import core_types_pkg::*;
(
  input  logic                          CLK,
  input  logic                          nRST,

  input  logic                          issue_valid,
  input  logic [3:0]                    issue_op,
  input  logic                          issue_A_forward,
  input  logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank,
  input  logic                          issue_B_forward,
  input  logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank,
  input  logic [LOG_PR_COUNT-1:0]       issue_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index,
  output logic                          issue_ready,

  input  logic                          A_reg_read_ack,
  input  logic                          A_reg_read_port,
  input  logic                          B_reg_read_ack,
  input  logic                          B_reg_read_port,
  input  logic [PRF_BANK_COUNT-1:0][1:0][31:0] reg_read_data_by_bank_by_port,

  input  logic [PRF_BANK_COUNT-1:0][31:0] forward_data_by_bank,

  output logic                          WB_valid,
  output logic [31:0]                   WB_data,
  output logic [LOG_PR_COUNT-1:0]       WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0]    WB_ROB_index,
  input  logic                          WB_ready
);

  logic                          oc_valid_q, oc_valid_d;
  logic                          oc_first_q, oc_first_d;
  logic [3:0]                    oc_op_q, oc_op_d;
  logic                          oc_a_fwd_q, oc_a_fwd_d;
  logic [LOG_PRF_BANK_COUNT-1:0] oc_a_bank_q, oc_a_bank_d;
  logic                          oc_b_fwd_q, oc_b_fwd_d;
  logic [LOG_PRF_BANK_COUNT-1:0] oc_b_bank_q, oc_b_bank_d;
  logic [LOG_PR_COUNT-1:0]       oc_pr_q, oc_pr_d;
  logic [LOG_ROB_ENTRIES-1:0]    oc_rob_q, oc_rob_d;
  logic                          oc_a_coll_q, oc_a_coll_d;
  logic                          oc_b_coll_q, oc_b_coll_d;
  logic [31:0]                   oc_a_q, oc_a_d;
  logic [31:0]                   oc_b_q, oc_b_d;

  logic                          wb_valid_q, wb_valid_d;
  logic [31:0]                   wb_data_q, wb_data_d;
  logic [LOG_PR_COUNT-1:0]       wb_pr_q, wb_pr_d;
  logic [LOG_ROB_ENTRIES-1:0]    wb_rob_q, wb_rob_d;

  logic        a_cap, b_cap;
  logic        a_rdy, b_rdy;
  logic [31:0] a_src, b_src;
  logic [31:0] a_val, b_val;
  logic        wb_free;
  logic        oc_adv;
  logic        issue_fire;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  // Forwarded operands are only on the bus during the first OC cycle.
  assign a_cap = oc_valid_q & ~oc_a_coll_q &
                 (oc_a_fwd_q ? oc_first_q : A_reg_read_ack);
  assign b_cap = oc_valid_q & ~oc_b_coll_q &
                 (oc_b_fwd_q ? oc_first_q : B_reg_read_ack);

  assign a_src = oc_a_fwd_q
               ? forward_data_by_bank[oc_a_bank_q]
               : reg_read_data_by_bank_by_port[oc_a_bank_q][A_reg_read_port];
  assign b_src = oc_b_fwd_q
               ? forward_data_by_bank[oc_b_bank_q]
               : reg_read_data_by_bank_by_port[oc_b_bank_q][B_reg_read_port];

  assign a_val = oc_a_coll_q ? oc_a_q : a_src;
  assign b_val = oc_b_coll_q ? oc_b_q : b_src;
  assign a_rdy = oc_a_coll_q | a_cap;
  assign b_rdy = oc_b_coll_q | b_cap;

  assign wb_free     = ~wb_valid_q | WB_ready;
  assign oc_adv      = oc_valid_q & a_rdy & b_rdy & wb_free;
  assign issue_ready = ~oc_valid_q | oc_adv;
  assign issue_fire  = issue_valid & issue_ready;

  assign shamt = b_val[4:0];

  always_comb begin
    alu_res = '0;
    unique case (oc_op_q)
      4'b0000: alu_res = a_val + b_val;
      4'b1000: alu_res = a_val - b_val;
      4'b0001: alu_res = a_val << shamt;
      4'b0010: alu_res = {31'b0, $signed(a_val) < $signed(b_val)};
      4'b0011: alu_res = {31'b0, a_val < b_val};
      4'b0100: alu_res = a_val ^ b_val;
      4'b0101: alu_res = a_val >> shamt;
      4'b1101: alu_res = 32'($signed(a_val) >>> shamt);
      4'b0110: alu_res = a_val | b_val;
      4'b0111: alu_res = a_val & b_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    oc_valid_d  = oc_valid_q;
    oc_first_d  = oc_first_q;
    oc_op_d     = oc_op_q;
    oc_a_fwd_d  = oc_a_fwd_q;
    oc_a_bank_d = oc_a_bank_q;
    oc_b_fwd_d  = oc_b_fwd_q;
    oc_b_bank_d = oc_b_bank_q;
    oc_pr_d     = oc_pr_q;
    oc_rob_d    = oc_rob_q;
    oc_a_coll_d = oc_a_coll_q;
    oc_b_coll_d = oc_b_coll_q;
    oc_a_d      = oc_a_q;
    oc_b_d      = oc_b_q;

    if (issue_fire) begin
      oc_valid_d  = 1'b1;
      oc_first_d  = 1'b1;
      oc_op_d     = issue_op;
      oc_a_fwd_d  = issue_A_forward;
      oc_a_bank_d = issue_A_bank;
      oc_b_fwd_d  = issue_B_forward;
      oc_b_bank_d = issue_B_bank;
      oc_pr_d     = issue_dest_PR;
      oc_rob_d    = issue_ROB_index;
      oc_a_coll_d = 1'b0;
      oc_b_coll_d = 1'b0;
    end else if (oc_adv) begin
      oc_valid_d  = 1'b0;
      oc_first_d  = 1'b0;
      oc_a_coll_d = 1'b0;
      oc_b_coll_d = 1'b0;
    end else if (oc_valid_q) begin
      oc_first_d = 1'b0;
      if (a_cap) begin
        oc_a_d      = a_src;
        oc_a_coll_d = 1'b1;
      end
      if (b_cap) begin
        oc_b_d      = b_src;
        oc_b_coll_d = 1'b1;
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_pr_d    = wb_pr_q;
    wb_rob_d   = wb_rob_q;
    if (oc_adv) begin
      wb_valid_d = 1'b1;
      wb_data_d  = alu_res;
      wb_pr_d    = oc_pr_q;
      wb_rob_d   = oc_rob_q;
    end else if (WB_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oc_valid_q  <= 1'b0;
      oc_first_q  <= 1'b0;
      oc_op_q     <= '0;
      oc_a_fwd_q  <= 1'b0;
      oc_a_bank_q <= '0;
      oc_b_fwd_q  <= 1'b0;
      oc_b_bank_q <= '0;
      oc_pr_q     <= '0;
      oc_rob_q    <= '0;
      oc_a_coll_q <= 1'b0;
      oc_b_coll_q <= 1'b0;
      oc_a_q      <= '0;
      oc_b_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_pr_q     <= '0;
      wb_rob_q    <= '0;
    end else begin
      oc_valid_q  <= oc_valid_d;
      oc_first_q  <= oc_first_d;
      oc_op_q     <= oc_op_d;
      oc_a_fwd_q  <= oc_a_fwd_d;
      oc_a_bank_q <= oc_a_bank_d;
      oc_b_fwd_q  <= oc_b_fwd_d;
      oc_b_bank_q <= oc_b_bank_d;
      oc_pr_q     <= oc_pr_d;
      oc_rob_q    <= oc_rob_d;
      oc_a_coll_q <= oc_a_coll_d;
      oc_b_coll_q <= oc_b_coll_d;
      oc_a_q      <= oc_a_d;
      oc_b_q      <= oc_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_pr_q     <= wb_pr_d;
      wb_rob_q    <= wb_rob_d;
    end
  end

  assign WB_valid     = wb_valid_q;
  assign WB_data      = wb_data_q;
  assign WB_PR        = wb_pr_q;
  assign WB_ROB_index = wb_rob_q;

endmodule

// File: tb/tb_alu_reg_pipeline.sv
// Scoreboard bench for alu_reg_pipeline: expected results queued at issue,
// compared in order whenever a writeback retires.
module tb_alu_reg_pipeline;
  import core_types_pkg::*;

  logic                          CLK = 1'b0;
  logic                          nRST;
  logic                          issue_valid;
  logic [3:0]                    issue_op;
  logic                          issue_A_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank;
  logic                          issue_B_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank;
  logic [LOG_PR_COUNT-1:0]       issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index;
  logic                          issue_ready;
  logic                          A_reg_read_ack;
  logic                          A_reg_read_port;
  logic                          B_reg_read_ack;
  logic                          B_reg_read_port;
  logic [PRF_BANK_COUNT-1:0][1:0][31:0] rd;
  logic [PRF_BANK_COUNT-1:0][31:0]      fwd;
  logic                          WB_valid;
  logic [31:0]                   WB_data;
  logic [LOG_PR_COUNT-1:0]       WB_PR;
  logic [LOG_ROB_ENTRIES-1:0]    WB_ROB_index;
  logic                          WB_ready;

  alu_reg_pipeline dut (
    .CLK                           (CLK),
    .nRST                          (nRST),
    .issue_valid                   (issue_valid),
    .issue_op                      (issue_op),
    .issue_A_forward               (issue_A_forward),
    .issue_A_bank                  (issue_A_bank),
    .issue_B_forward               (issue_B_forward),
    .issue_B_bank                  (issue_B_bank),
    .issue_dest_PR                 (issue_dest_PR),
    .issue_ROB_index               (issue_ROB_index),
    .issue_ready                   (issue_ready),
    .A_reg_read_ack                (A_reg_read_ack),
    .A_reg_read_port               (A_reg_read_port),
    .B_reg_read_ack                (B_reg_read_ack),
    .B_reg_read_port               (B_reg_read_port),
    .reg_read_data_by_bank_by_port (rd),
    .forward_data_by_bank          (fwd),
    .WB_valid                      (WB_valid),
    .WB_data                       (WB_data),
    .WB_PR                         (WB_PR),
    .WB_ROB_index                  (WB_ROB_index),
    .WB_ready                      (WB_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]                d;
    logic [LOG_PR_COUNT-1:0]    pr;
    logic [LOG_ROB_ENTRIES-1:0] rob;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0]  bo[32];
  logic [31:0] ba[32];
  logic [31:0] bb[32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r = 32'h0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a + (~b) + 32'd1;
      4'b0001: r = a << sh;
      4'b0010: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      4'b0011: r = {31'b0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b1101: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [LOG_PR_COUNT-1:0] pr,
                      input logic [LOG_ROB_ENTRIES-1:0] rob);
    exp_t e;
    e.d = d;
    e.pr = pr;
    e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic set_iss(input logic [3:0] op,
                         input logic af, input logic [1:0] ab,
                         input logic bf, input logic [1:0] bbk,
                         input logic [LOG_PR_COUNT-1:0] pr,
                         input logic [LOG_ROB_ENTRIES-1:0] rob);
    issue_valid     = 1'b1;
    issue_op        = op;
    issue_A_forward = af;
    issue_A_bank    = ab;
    issue_B_forward = bf;
    issue_B_bank    = bbk;
    issue_dest_PR   = pr;
    issue_ROB_index = rob;
  endtask

  // Single forwarded op with an explicit expected result.
  task automatic issue_fwd(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input logic [LOG_PR_COUNT-1:0] pr,
                           input logic [LOG_ROB_ENTRIES-1:0] rob);
    set_iss(op, 1'b1, 2'd0, 1'b1, 2'd1, pr, rob);
    push(exp, pr, rob);
    tick();
    issue_valid = 1'b0;
    fwd[0] = a;
    fwd[1] = b;
    tick();
    fwd[0] = 32'hDEAD_BEEF;
    fwd[1] = 32'h1234_5678;
    @(negedge CLK);
    chk("lat_n2", WB_valid, 1);
    tick();
  endtask

  task automatic b2b(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        set_iss(bo[i], 1'b1, 2'd0, 1'b1, 2'd1, 7'(i + 40), 6'(i));
        push(ref_alu(bo[i], ba[i], bb[i]), 7'(i + 40), 6'(i));
      end else begin
        issue_valid = 1'b0;
      end
      if (i > 0) begin
        fwd[0] = ba[i-1];
        fwd[1] = bb[i-1];
      end
      tick();
      if (i > 0) begin
        @(negedge CLK);
        chk("b2b_valid", WB_valid, 1);
      end
    end
    fwd[0] = 32'hCAFE_F00D;
    fwd[1] = 32'h0BAD_0BAD;
    @(negedge CLK);
    chk("b2b_end", WB_valid, 0);
    tick();
  endtask

  always @(negedge CLK) begin
    if (nRST && WB_valid && WB_ready) begin
      if (sb.size() == 0) begin
        chk("wb_extra", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", WB_data, e.d);
        chk("wb_pr", 32'(WB_PR), 32'(e.pr));
        chk("wb_rob", 32'(WB_ROB_index), 32'(e.rob));
      end
    end
  end

  initial begin
    nRST = 1'b0;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_A_forward = 1'b0;
    issue_A_bank = '0;
    issue_B_forward = 1'b0;
    issue_B_bank = '0;
    issue_dest_PR = '0;
    issue_ROB_index = '0;
    A_reg_read_ack = 1'b0;
    A_reg_read_port = 1'b0;
    B_reg_read_ack = 1'b0;
    B_reg_read_port = 1'b0;
    rd = '0;
    fwd = '0;
    WB_ready = 1'b1;

    @(negedge CLK);
    chk("rst_wbv", WB_valid, 0);
    chk("rst_data", WB_data, 0);
    chk("rst_pr", 32'(WB_PR), 0);
    chk("rst_rob", 32'(WB_ROB_index), 0);
    chk("rst_rdy", issue_ready, 1);
    tick();
    nRST = 1'b1;
    tick();

    // forwarded ADD, latency and tag echo
    issue_fwd(4'b0000, 32'd5, 32'd7, 32'd12, 7'h55, 6'h2A);

    issue_fwd(4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 7'd1, 6'd1);
    issue_fwd(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 7'd2, 6'd2);
    issue_fwd(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 7'd3, 6'd3);
    issue_fwd(4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 7'd4, 6'd4);
    issue_fwd(4'b0001, 32'd1, 32'h21, 32'd2, 7'd5, 6'd5);
    issue_fwd(4'b0101, 32'h8000_0000, 32'd31, 32'd1, 7'd6, 6'd6);
    issue_fwd(4'b1001, 32'd9, 32'd9, 32'd0, 7'd7, 6'd7);
    issue_fwd(4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200,
              7'd8, 6'd8);

    // late register reads, stale second ack on A must be ignored
    set_iss(4'b0110, 1'b0, 2'd2, 1'b0, 2'd3, 7'd30, 6'd30);
    push(32'hFF, 7'd30, 6'd30);
    tick();
    set_iss(4'b0000, 1'b1, 2'd0, 1'b1, 2'd1, 7'd31, 6'd31);
    A_reg_read_ack = 1'b1;
    A_reg_read_port = 1'b1;
    rd[2][1] = 32'hF0;
    @(negedge CLK);
    chk("late_rdy_n1", issue_ready, 0);
    tick();
    rd[2][1] = 32'hAA;
    @(negedge CLK);
    chk("late_rdy_n2", issue_ready, 0);
    tick();
    A_reg_read_ack = 1'b0;
    B_reg_read_ack = 1'b1;
    B_reg_read_port = 1'b0;
    rd[3][0] = 32'h0F;
    @(negedge CLK);
    chk("late_rdy_n3", issue_ready, 1);
    push(32'd42, 7'd31, 6'd31);
    tick();
    B_reg_read_ack = 1'b0;
    issue_valid = 1'b0;
    fwd[0] = 32'd40;
    fwd[1] = 32'd2;
    @(negedge CLK);
    chk("late_wb_n4", WB_valid, 1);
    chk("late_data", WB_data, 32'hFF);
    tick();
    fwd = '0;
    @(negedge CLK);
    chk("late_op2_v", WB_valid, 1);
    tick();

    // backpressure with forward data only in the first OC cycle
    WB_ready = 1'b0;
    set_iss(4'b0000, 1'b1, 2'd0, 1'b1, 2'd1, 7'd10, 6'd10);
    push(32'd3, 7'd10, 6'd10);
    tick();
    issue_valid = 1'b0;
    fwd[0] = 32'd1;
    fwd[1] = 32'd2;
    tick();
    set_iss(4'b0100, 1'b1, 2'd0, 1'b1, 2'd1, 7'd11, 6'd11);
    push(32'hF00F_F00F, 7'd11, 6'd11);
    @(negedge CLK);
    chk("bp_rdy_empty", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    fwd[0] = 32'hFF00_FF00;
    fwd[1] = 32'h0F0F_0F0F;
    @(negedge CLK);
    chk("bp_rdy_stall", issue_ready, 0);
    chk("bp_hold_v", WB_valid, 1);
    chk("bp_hold_d", WB_data, 32'd3);
    tick();
    fwd[0] = 32'h1111_1111;
    fwd[1] = 32'h2222_2222;
    @(negedge CLK);
    chk("bp_rdy_stall2", issue_ready, 0);
    chk("bp_hold_d2", WB_data, 32'd3);
    chk("bp_hold_pr", 32'(WB_PR), 32'd10);
    tick();
    WB_ready = 1'b1;
    @(negedge CLK);
    chk("bp_rdy_rel", issue_ready, 1);
    tick();
    @(negedge CLK);
    chk("bp_op2_v", WB_valid, 1);
    tick();
    @(negedge CLK);
    chk("bp_drained", WB_valid, 0);
    tick();

    // reset with both stages full; these ops must never write back
    WB_ready = 1'b0;
    set_iss(4'b0000, 1'b1, 2'd0, 1'b1, 2'd1, 7'd20, 6'd20);
    tick();
    issue_valid = 1'b0;
    fwd[0] = 32'd9;
    fwd[1] = 32'd9;
    tick();
    set_iss(4'b1000, 1'b1, 2'd0, 1'b1, 2'd1, 7'd21, 6'd21);
    tick();
    issue_valid = 1'b0;
    @(negedge CLK);
    chk("full_wbv", WB_valid, 1);
    chk("full_rdy", issue_ready, 0);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_wbv", WB_valid, 0);
    chk("arst_rdy", issue_ready, 1);
    chk("arst_data", WB_data, 0);
    chk("arst_pr", 32'(WB_PR), 0);
    tick();
    nRST = 1'b1;
    WB_ready = 1'b1;
    @(negedge CLK);
    chk("post_rst_v", WB_valid, 0);
    chk("post_rst_rdy", issue_ready, 1);
    issue_fwd(4'b0110, 32'hA000_0000, 32'h0000_000B, 32'hA000_000B,
              7'd22, 6'd22);
    @(negedge CLK);
    chk("post_rst_quiet", WB_valid, 0);
    tick();

    // back-to-back: fixed four, then a random run
    bo[0] = 4'b0000; ba[0] = 32'd1;          bb[0] = 32'd2;
    bo[1] = 4'b1000; ba[1] = 32'd10;         bb[1] = 32'd3;
    bo[2] = 4'b0001; ba[2] = 32'd1;          bb[2] = 32'd31;
    bo[3] = 4'b1101; ba[3] = 32'h8000_0000;  bb[3] = 32'd4;
    b2b(4);
    for (int i = 0; i < 20; i++) begin
      bo[i] = 4'($urandom_range(0, 15));
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    b2b(20);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_reg_pipeline.md
ALU_REG_PIPELINE -- requirements
Module: alu_reg_pipeline

Interface
Parameters: none; widths come from core_types_pkg (LOG_PR_COUNT, LOG_ROB_ENTRIES, PRF_BANK_COUNT, LOG_PRF_BANK_COUNT).
REQ-001 SHALL have one clock and an asynchronous, active-low reset: CLK in 1, nRST in 1.
REQ-002 SHALL provide issue ports from alu_reg_mdu_iq:
- issue_valid in 1, issue_op in 4
- issue_A_forward in 1, issue_A_bank in LOG_PRF_BANK_COUNT
- issue_B_forward in 1, issue_B_bank in LOG_PRF_BANK_COUNT
- issue_dest_PR in LOG_PR_COUNT, issue_ROB_index in LOG_ROB_ENTRIES
REQ-003 SHALL provide issue_ready out 1 (pipeline ready to the IQ).
REQ-004 SHALL provide PRF read response ports:
- A_reg_read_ack in 1, A_reg_read_port in 1
- B_reg_read_ack in 1, B_reg_read_port in 1
- reg_read_data_by_bank_by_port in [PRF_BANK_COUNT][2][32]
REQ-005 SHALL provide forward_data_by_bank in [PRF_BANK_COUNT][32] (writeback bus data, valid in the cycle after the matching tag broadcast).
REQ-006 SHALL provide writeback ports:
- WB_valid out 1, WB_data out 32
- WB_PR out LOG_PR_COUNT, WB_ROB_index out LOG_ROB_ENTRIES
- WB_ready in 1

Function
REQ-007 SHALL have two stages, OC (operand collect) and WB, each holding at most one op.
REQ-008 SHALL accept an issue when issue_valid & issue_ready, latching all issue fields into OC with operand-collected flags cleared and first_cycle=1.
REQ-009 SHALL compute issue_ready = ~OC_valid | OC_advance; this is combinational and may depend on acks and WB_ready in the same cycle.
REQ-010 Forwarded operands: in OC's first cycle only, when X_forward=1, operand X SHALL capture forward_data_by_bank[X_bank] and mark X collected, even if OC stalls.
REQ-011 Register-read operands: when X_forward=0 and X_reg_read_ack=1, operand X SHALL capture reg_read_data_by_bank_by_port[X_bank][X_reg_read_port] and mark X collected. An ack arriving for an already-collected operand SHALL be ignored.
REQ-012 SHALL define OC_advance = OC_valid & (A collected or collecting this cycle) & (B collected or collecting this cycle) & (~WB_valid | WB_ready).
REQ-013 On OC_advance, SHALL compute the result from the current-cycle operand values and load WB with data, dest_PR and ROB_index. Simultaneous OC_advance and a new issue SHALL both occur.
REQ-014 Op encoding ({funct7[5], funct3}):
- 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU
- 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
- all other encodings produce 0
REQ-015 Arithmetic SHALL be 32-bit with wraparound. Shifts SHALL use B[4:0]. SLT/SLTU SHALL produce 0 or 1.
REQ-016 WB_valid SHALL hold with stable fields until WB_ready. It SHALL clear on WB_ready unless refilled in the same cycle.
REQ-017 Minimum latency SHALL be issue at cycle N -> WB_valid at N+2. Sustained throughput SHALL be 1 op/cycle when operands arrive on time and WB_ready=1.
REQ-018 Ops SHALL complete strictly in issue order; no op may be dropped or duplicated.

Reset
REQ-019 While nRST=0, SHALL set OC_valid=0, WB_valid=0, collected flags=0 and all data/PR/ROB registers=0. Outputs: WB_valid=0, WB_data=0, WB_PR=0, WB_ROB_index=0, issue_ready=1.
REQ-020 Reset asserted mid-operation SHALL discard in-flight ops immediately (asynchronously). The first cycle after release SHALL accept a new issue.

Verification
REQ-021 Forward ADD: issue op=0000, both forward, at N; forward data at N+1 A=5, B=7 -> at N+2 WB_valid=1, WB_data=12, dest_PR and ROB_index echo the issued values.
REQ-022 Shift/compare:
- SRA A=0x80000000, B=4 -> 0xF8000000
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0
- SUB 3-5 -> 0xFFFFFFFE
REQ-023 Late register read: issue at N with both non-forward; A ack at N+1 (data 0xF0), B ack at N+3 (data 0x0F), op OR -> WB_valid at N+4 with 0xFF; issue_ready=0 at N+1..N+2 while a second issue is pending.
REQ-024 Backpressure: WB_ready=0 with op1 in WB; op2 issues with forward data present only in its first cycle -> op2 holds in OC, issue_ready=0. Raising WB_ready -> op1 retires, then op2 retires with the correctly captured forward value.
REQ-025 Reset mid-operation: nRST=0 with both stages full -> WB_valid=0 and issue_ready=1 immediately. After release, one issued op completes with no stale writeback.
REQ-026 Back-to-back: 4 forward ops issued on consecutive cycles with WB_ready=1 -> 4 consecutive WB_valid cycles, in order, with correct data.
